// File: rtl/sym_packed_matrix_unpacker_if.sv
// Stream bundle for the symmetric packed-matrix unpacker.
// The packed upper-triangle input and the full-matrix output share one interface.
interface sym_packed_matrix_unpacker_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_row;
    logic [IDX_W-1:0]  out_col;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col, out_last
    );
endinterface

// File: rtl/sym_packed_matrix_unpacker.sv
// Buffers a packed upper-triangle symmetric matrix and replays it as a full
// NxN row-major stream, mirroring the lower triangle from stored entries.
//
// state | meaning
// LOAD  | accepting packed words into the buffer, output idle
// EMIT  | presenting full-matrix elements, input stalled
module sym_packed_matrix_unpacker #(
    parameter int DATA_W = 32,
    parameter int N      = 4,
    parameter int IDX_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    sym_packed_matrix_unpacker_if.slave  bus,
    output logic                         busy
);
    localparam int P  = N * (N + 1) / 2;
    localparam int AW = (P > 1) ? $clog2(P) : 1;
    localparam logic [AW-1:0]    LAST_ADDR = AW'(P - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);

    typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

    state_t            state, state_d;
    logic [AW-1:0]     wr_ptr;
    logic [DATA_W-1:0] mem [P];
    logic [IDX_W-1:0]  nxt_row, nxt_col, step_row, step_col;
    logic [AW-1:0]     nxt_addr, step_addr;
    logic              in_hs, out_hs, load_done;

    assign in_hs     = bus.in_valid && bus.in_ready;
    assign out_hs    = bus.out_valid && bus.out_ready;
    assign load_done = in_hs && (wr_ptr == LAST_ADDR);
    assign busy      = (state != LOAD) || (wr_ptr != '0);

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_d;
    end

    always_comb begin
        state_d       = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (load_done) state_d = EMIT;
            end
            EMIT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready && bus.out_last) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_hs && !rst) mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst)        wr_ptr <= '0;
        else if (in_hs) wr_ptr <= load_done ? '0 : wr_ptr + AW'(1);
    end

    // Lower-triangle entries (col < row) walk down a stored column: stride N-1-col.
    always_comb begin
        step_row  = nxt_row;
        step_col  = nxt_col + IDX_W'(1);
        step_addr = nxt_addr + AW'(1);
        if (nxt_col == LAST_IDX) begin
            step_col  = '0;
            step_row  = (nxt_row == LAST_IDX) ? nxt_row : nxt_row + IDX_W'(1);
            step_addr = AW'(nxt_row) + AW'(1);
        end else if (nxt_col < nxt_row) begin
            step_addr = nxt_addr + (AW'(N - 1) - AW'(nxt_col));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_data <= '0;
            bus.out_row  <= '0;
            bus.out_col  <= '0;
            bus.out_last <= 1'b0;
            nxt_row      <= '0;
            nxt_col      <= '0;
            nxt_addr     <= '0;
        end else if (load_done) begin
            bus.out_data <= mem[0];
            bus.out_row  <= '0;
            bus.out_col  <= '0;
            bus.out_last <= 1'b0;
            nxt_row      <= '0;
            nxt_col      <= IDX_W'(1);
            nxt_addr     <= AW'(1);
        end else if (out_hs && !bus.out_last) begin
            bus.out_data <= mem[nxt_addr];
            bus.out_row  <= nxt_row;
            bus.out_col  <= nxt_col;
            bus.out_last <= (nxt_row == LAST_IDX) && (nxt_col == LAST_IDX);
            nxt_row      <= step_row;
            nxt_col      <= step_col;
            nxt_addr     <= step_addr;
        end
    end
endmodule

// File: tb/tb_sym_packed_matrix_unpacker.sv
// Directed bench for sym_packed_matrix_unpacker with N=4: table of expected
// full-matrix elements plus hand-written reset and back-to-back sequences.
module tb_sym_packed_matrix_unpacker;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int IW = 4;
    localparam int P  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    sym_packed_matrix_unpacker_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

    sym_packed_matrix_unpacker #(.DATA_W(DW), .N(N), .IDX_W(IW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    typedef struct {
        int row;
        int col;
        int pidx;
        bit last;
    } vec_t;

    vec_t tbl [16];
    int   pid [16] = '{0, 1, 2, 3, 1, 4, 5, 6, 2, 5, 7, 8, 3, 6, 8, 9};
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk(nm, {bus.in_ready, bus.out_valid, busy, bus.out_data, bus.out_row, bus.out_col, bus.out_last},
            {1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0});
    endtask

    task automatic load_words(input int base, input int count, input bit rnd);
        int k = 0;
        int guard = 0;
        bit hs;
        while (k < count && guard < 400) begin
            bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = DW'(base + k);
            chk("no_out_valid_in_load", {63'd0, bus.out_valid}, 64'd0);
            hs = bus.in_valid && bus.in_ready;
            tick();
            guard++;
            if (hs) k++;
        end
        bus.in_valid = 1'b0;
        chk("load_words_accepted", 64'(k), 64'(count));
        if (count == P) begin
            chk("first_out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("in_ready_in_emit", {63'd0, bus.in_ready}, 64'd0);
        end
    endtask

    task automatic run_emit(input int base, input bit toggle, input int n_stop);
        int idx = 0;
        int cyc = 0;
        bit hs, rdy;
        while (idx < n_stop && cyc < 100) begin
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.out_ready = rdy;
            chk("emit_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("emit_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk($sformatf("elem%0d", idx),
                {23'd0, bus.out_data, bus.out_row, bus.out_col, bus.out_last},
                {23'd0, DW'(base + tbl[idx].pidx), IW'(tbl[idx].row), IW'(tbl[idx].col), tbl[idx].last});
            hs = bus.out_valid && rdy;
            tick();
            cyc++;
            if (hs) idx++;
        end
        bus.out_ready = 1'b0;
        chk("emit_count", 64'(idx), 64'(n_stop));
        if (n_stop == 16) begin
            chk("emit_cycles", 64'(cyc), toggle ? 64'd31 : 64'd16);
            chk("post_emit_valid", {63'd0, bus.out_valid}, 64'd0);
            chk("post_emit_in_ready", {63'd0, bus.in_ready}, 64'd1);
            chk("post_emit_busy", {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].row  = i / N;
            tbl[i].col  = i % N;
            tbl[i].pidx = pid[i];
            tbl[i].last = (i == 15);
        end
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk_reset("reset_state");
        rst = 1'b0;

        // back-to-back load, full-rate drain
        load_words(1, P, 1'b0);
        run_emit(1, 1'b0, 16);

        // stalled drain
        load_words(1, P, 1'b0);
        run_emit(1, 1'b1, 16);

        // gappy load; out_ready held high while loading must be ignored
        bus.out_ready = 1'b1;
        load_words(1, P, 1'b1);
        run_emit(1, 1'b0, 16);

        // two matrices back to back, next word held during first emit
        load_words(1, P, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd101;
        run_emit(1, 1'b0, 16);
        load_words(101, P, 1'b0);
        run_emit(101, 1'b0, 16);

        // reset mid-load
        load_words(1, 6, 1'b0);
        chk("busy_mid_load", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("rst_mid_load");
        load_words(1, P, 1'b0);
        run_emit(1, 1'b0, 16);

        // reset mid-emit at element 7
        load_words(1, P, 1'b0);
        run_emit(1, 1'b0, 7);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        chk_reset("rst_mid_emit");
        load_words(1, P, 1'b0);
        run_emit(1, 1'b0, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
